// File: rtl/pulse_count_scheduler.sv
// pulse_count_scheduler: round-robin shared rising-edge counter.
// One channel is granted at a time. Rising edges on that channel are counted
// until the latched target is reached or the COUNT phase times out. The result
// registers then hold the outcome until the next job completes.
module pulse_count_scheduler #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 1000,
    parameter int CYC_W   = $clog2(TIMEOUT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           req,
    input  logic [N_CH-1:0]           sig,
    input  logic [CNT_W-1:0]          target,
    output logic [N_CH-1:0]           grant,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(N_CH)-1:0]   done_ch,
    output logic                      timed_out,
    output logic [CNT_W-1:0]          result_count,
    output logic [CYC_W-1:0]          result_cycles
);

    localparam int CH_W = $clog2(N_CH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    rr_q, rr_d;
    logic [CH_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic               prev_q, prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CYC_W-1:0]   timer_q, timer_d;
    logic [N_CH-1:0]    grant_q, grant_d;
    logic [CH_W-1:0]    done_ch_q, done_ch_d;
    logic               timed_out_q, timed_out_d;
    logic [CNT_W-1:0]   res_count_q, res_count_d;
    logic [CYC_W-1:0]   res_cycles_q, res_cycles_d;

    // Arbiter: cand[i] is the channel examined i-th, starting from rr and wrapping.
    logic [CH_W-1:0]    cand [N_CH];
    logic               arb_valid;
    logic [CH_W-1:0]    arb_idx;
    logic [CH_W-1:0]    rr_after;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_cand
            logic [CH_W:0] sum;
            assign sum      = {1'b0, rr_q} + (CH_W+1)'(gi);
            assign cand[gi] = (sum >= (CH_W+1)'(N_CH)) ? CH_W'(sum - (CH_W+1)'(N_CH))
                                                       : sum[CH_W-1:0];
        end
    endgenerate

    // Pick the first requesting channel in rotated order (lowest i wins).
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[cand[i]]) begin
                arb_valid = 1'b1;
                arb_idx   = cand[i];
            end
        end
    end

    // The pointer moves past the winner, so a held request drops to lowest priority.
    assign rr_after = (arb_idx == CH_W'(N_CH - 1)) ? '0 : arb_idx + CH_W'(1);

    // Edge detection on the granted channel, relative to the previous sample.
    logic               sig_sel;
    logic               sig_rise;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CYC_W-1:0]   timer_inc;
    logic               hit;
    logic               tmo;

    assign sig_sel   = sig[sel_q];
    assign sig_rise  = sig_sel & ~prev_q;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign timer_inc = timer_q + CYC_W'(1);
    assign hit       = sig_rise && (cnt_inc == target_q);
    assign tmo       = (timer_q == CYC_W'(TIMEOUT - 1));

    // Next-state and datapath updates; every register holds unless its state acts on it.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        sel_d        = sel_q;
        target_d     = target_q;
        prev_d       = prev_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        grant_d      = grant_q;
        done_ch_d    = done_ch_q;
        timed_out_d  = timed_out_q;
        res_count_d  = res_count_q;
        res_cycles_d = res_cycles_q;

        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (arb_valid) begin
                    state_d          = S_ARM;
                    sel_d            = arb_idx;
                    target_d         = target;
                    rr_d             = rr_after;
                    grant_d[arb_idx] = 1'b1;
                end
            end
            S_ARM: begin
                // Seed prev with the current level so a level already high is not an edge.
                prev_d  = sig_sel;
                cnt_d   = '0;
                timer_d = '0;
                if (target_q == '0) begin
                    state_d      = S_DONE;
                    grant_d      = '0;
                    done_ch_d    = sel_q;
                    timed_out_d  = 1'b0;
                    res_count_d  = '0;
                    res_cycles_d = '0;
                end else begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                prev_d = sig_sel;
                if (sig_rise) begin
                    cnt_d = cnt_inc;
                end
                // Completion is checked first so it wins over a coincident timeout.
                if (hit) begin
                    state_d      = S_DONE;
                    grant_d      = '0;
                    done_ch_d    = sel_q;
                    timed_out_d  = 1'b0;
                    res_count_d  = cnt_inc;
                    res_cycles_d = timer_inc;
                end else if (tmo) begin
                    state_d      = S_DONE;
                    grant_d      = '0;
                    done_ch_d    = sel_q;
                    timed_out_d  = 1'b1;
                    res_count_d  = sig_rise ? cnt_inc : cnt_q;
                    res_cycles_d = timer_inc;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any job and clears all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_q         <= '0;
            sel_q        <= '0;
            target_q     <= '0;
            prev_q       <= 1'b0;
            cnt_q        <= '0;
            timer_q      <= '0;
            grant_q      <= '0;
            done_ch_q    <= '0;
            timed_out_q  <= 1'b0;
            res_count_q  <= '0;
            res_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            sel_q        <= sel_d;
            target_q     <= target_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            grant_q      <= grant_d;
            done_ch_q    <= done_ch_d;
            timed_out_q  <= timed_out_d;
            res_count_q  <= res_count_d;
            res_cycles_q <= res_cycles_d;
        end
    end

    assign grant         = grant_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign done_ch       = done_ch_q;
    assign timed_out     = timed_out_q;
    assign result_count  = res_count_q;
    assign result_cycles = res_cycles_q;

endmodule

// File: tb/tb_pulse_count_scheduler.sv
// Testbench for pulse_count_scheduler: table of jobs with hand-derived expected
// results, a scoreboard queue popped on each done, and a mid-job reset sequence.
module tb_pulse_count_scheduler;

    localparam int N_CH    = 4;
    localparam int CNT_W   = 5;
    localparam int TIMEOUT = 20;
    localparam int CYC_W   = $clog2(TIMEOUT + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic [N_CH-1:0]    req;
    logic [N_CH-1:0]    sig;
    logic [CNT_W-1:0]   target;
    logic [N_CH-1:0]    grant;
    logic               busy;
    logic               done;
    logic [1:0]         done_ch;
    logic               timed_out;
    logic [CNT_W-1:0]   result_count;
    logic [CYC_W-1:0]   result_cycles;

    pulse_count_scheduler #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .CYC_W   (CYC_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .sig           (sig),
        .target        (target),
        .grant         (grant),
        .busy          (busy),
        .done          (done),
        .done_ch       (done_ch),
        .timed_out     (timed_out),
        .result_count  (result_count),
        .result_cycles (result_cycles)
    );

    always #5 clk = ~clk;

    // One job: request mask, target, pulse train shape, and the hand-derived outcome.
    // Pulses are one cycle high at COUNT cycles gap*k+gap-1 (k < npulse);
    // pre_high holds the channel high through the grant, ARM and COUNT cycle 0.
    typedef struct {
        logic [3:0] req_mask;
        int         tgt;
        int         npulse;
        int         gap;
        bit         pre_high;
        bit         xtalk;
        bit         hold;
        int         exp_ch;
        int         exp_count;
        bit         exp_to;
        int         exp_cycles;
    } vec_t;

    typedef struct {
        int ch;
        int count;
        bit to;
        int cycles;
    } exp_t;

    vec_t vecs [11];
    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit pat(input int j, input int gap, input int npulse, input bit pre_high);
        return (pre_high && j == 0) || (((j % gap) == gap - 1) && ((j / gap) < npulse));
    endfunction

    // Drive one job from an IDLE negedge; returns at the IDLE negedge after DONE.
    task automatic run_job(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        bit   seen;
        int   n;
        target = CNT_W'(v.tgt);
        req    = v.req_mask;
        sig    = '0;
        sig[v.exp_ch] = v.pre_high;
        e.ch = v.exp_ch; e.count = v.exp_count; e.to = v.exp_to; e.cycles = v.exp_cycles;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check("grant_arm", int'(grant), 1 << v.exp_ch);
        check("busy_arm", int'(busy), 1);
        seen = 1'b0;
        n    = 0;
        for (int c = 1; c <= TIMEOUT + 10; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                n    = c;
                break;
            end
            sig = (v.xtalk && c[0]) ? '1 : '0;
            sig[v.exp_ch] = pat(c - 1, v.gap, v.npulse, v.pre_high);
        end
        check("done_seen", int'(seen), 1);
        if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            if (seen) begin
                check("done_ch", int'(done_ch), got.ch);
                check("result_count", int'(result_count), got.count);
                check("timed_out", int'(timed_out), int'(got.to));
                check("result_cycles", int'(result_cycles), got.cycles);
                check("done_latency", n, got.cycles + 1);
                check("grant_done", int'(grant), 0);
            end
        end
        $display("job %0d: ch=%0d count=%0d cycles=%0d timed_out=%0d latency=%0d",
                 idx, done_ch, result_count, result_cycles, timed_out, n);
        sig = '0;
        if (!v.hold) req = '0;
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("busy_idle", int'(busy), 0);
        check("result_held", int'(result_count), v.exp_count);
    endtask

    initial begin
        //          req      tgt np gap pre xt hold ch cnt to cyc
        vecs[0]  = '{4'b0010, 3, 3, 2, 1'b0, 1'b0, 1'b0, 1, 3, 1'b0, 6};   // single job
        vecs[1]  = '{4'b0100, 5, 2, 2, 1'b0, 1'b0, 1'b0, 2, 2, 1'b1, 20};  // timeout
        vecs[2]  = '{4'b1000, 0, 0, 2, 1'b0, 1'b1, 1'b0, 3, 0, 1'b0, 0};   // target 0
        vecs[3]  = '{4'b0001, 4, 4, 3, 1'b0, 1'b1, 1'b0, 0, 4, 1'b0, 12};  // crosstalk
        vecs[4]  = '{4'b0010, 5, 5, 4, 1'b0, 1'b0, 1'b0, 1, 5, 1'b0, 20};  // edge at last cycle
        vecs[5]  = '{4'b0001, 6, 6, 4, 1'b0, 1'b0, 1'b0, 0, 5, 1'b1, 20};  // wrap, edge past limit
        vecs[6]  = '{4'b1111, 2, 2, 3, 1'b1, 1'b0, 1'b1, 0, 2, 1'b0, 6};   // rr + level high in ARM
        vecs[7]  = '{4'b1111, 1, 1, 2, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0, 2};
        vecs[8]  = '{4'b1111, 3, 3, 2, 1'b0, 1'b1, 1'b1, 2, 3, 1'b0, 6};
        vecs[9]  = '{4'b1111, 2, 2, 5, 1'b0, 1'b0, 1'b1, 3, 2, 1'b0, 10};
        vecs[10] = '{4'b1111, 1, 1, 3, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 3};

        rst    = 1'b1;
        req    = '0;
        sig    = '0;
        target = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", int'(grant), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_done_ch", int'(done_ch), 0);
        check("rst_timed_out", int'(timed_out), 0);
        check("rst_count", int'(result_count), 0);
        check("rst_cycles", int'(result_cycles), 0);
        $display("reset: grant=%0d busy=%0d done=%0d", grant, busy, done);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i <= 5; i++) run_job(i, vecs[i]);

        // Reset in the middle of a COUNT phase: job is dropped, outputs cleared.
        target = CNT_W'(10);
        req    = 4'b0100;
        sig    = '0;
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            sig[2] = c[0];
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_grant", int'(grant), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_timed_out", int'(timed_out), 0);
        check("midrst_count", int'(result_count), 0);
        check("midrst_cycles", int'(result_cycles), 0);
        $display("mid-count reset: grant=%0d busy=%0d count=%0d", grant, busy, result_count);
        rst = 1'b0;
        req = '0;
        sig = '0;
        @(negedge clk);
        check("midrst_no_done", int'(done), 0);
        check("midrst_idle", int'(busy), 0);

        for (int i = 6; i <= 10; i++) run_job(i, vecs[i]);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_count_scheduler.md
# pulse_count_scheduler

Shares one edge-counting datapath among `N_CH` pulse-signal channels. Requesters raise a level request. A round-robin arbiter grants one channel at a time. The block then counts rising edges on the granted channel until a configured target is reached or a cycle timeout expires, and reports edge count, elapsed cycles and timeout status. It sits between the coprocessor's command logic and the external pulse inputs.

## Interface
- `N_CH`, 4, number of requester/signal channels (2..8)
- `CNT_W`, 5, width of edge target and edge count
- `TIMEOUT`, 1000, maximum COUNT-state cycles per job (≥1)
- `CYC_W`, $clog2(TIMEOUT+1), width of the elapsed-cycle result
- `clk` in 1: clock, all logic on rising edge
- `rst` in 1: reset, synchronous, active-high
- `req` in N_CH: level request per channel
- `sig` in N_CH: pulse inputs, already synchronous to clk (synchronizers upstream)
- `target` in CNT_W: edges to count; sampled in the grant cycle
- `grant` out N_CH: one-hot; high for the granted channel during ARM and COUNT
- `busy` out 1: high in ARM, COUNT and DONE
- `done` out 1: one-cycle pulse in DONE
- `done_ch` out $clog2(N_CH): channel index of the finished job; held until the next DONE
- `timed_out` out 1: job ended by timeout; held until the next DONE
- `result_count` out CNT_W: edges counted; held until the next DONE
- `result_cycles` out CYC_W: COUNT cycles elapsed; held until the next DONE

## Operation
- **States:**
  - IDLE → ARM when any `req` bit is high.
  - ARM → COUNT.
  - ARM → DONE if the latched target is 0.
  - COUNT → DONE on target reached or timeout.
  - DONE → IDLE unconditionally.
- **Arbitration (IDLE):**
  - Search starts at pointer `rr` and wraps modulo N_CH; the first set `req` bit wins.
  - On grant: latch `sel`, latch `target`, set `rr <= sel+1` (wraps).
  - Arbitration runs only in IDLE; `req` changes at other times are ignored.
- **ARM:**
  - `prev <= sig[sel]`, `cnt <= 0`, `timer <= 0`.
  - Prevents a level already high from counting as an edge.
- **COUNT, each cycle:**
  - `edge = sig[sel] & ~prev`; `prev <= sig[sel]`; `timer <= timer+1`.
  - On `edge`, `cnt <= cnt+1`.
  - If `edge` and `cnt+1 == target_l`: go to DONE, `timed_out=0`.
  - Else if `timer == TIMEOUT-1`: go to DONE, `timed_out=1`.
  - Completing edge and timeout in the same cycle: completion wins, `timed_out=0`.
- **Result registers:** loaded on entry to DONE.
  - `result_count` = final cnt, including the completing edge.
  - `result_cycles` = timer+1; 0 for a target-0 job.
- **Width rules:**
  - `cnt` never exceeds `target_l` ≤ 2^CNT_W-1, so no wrap.
  - `timer` never exceeds TIMEOUT-1.
- **Requester protocol:**
  - The requester drops `req` after seeing `done` with its `done_ch`.
  - A held `req` is re-arbitrated at lowest priority (fairness via `rr`).
- **Reset:**
  - Applies from any state; next state IDLE, `rr=0`.
  - All outputs 0; a job in progress is abandoned with no `done`.

## Timing
- `req` high in IDLE at cycle t → `grant`/`busy` high at t+1 (ARM). COUNT begins at t+2.
- `grant` is registered, one-hot, and low in IDLE and DONE.
- Edge counted in the cycle `sig[sel]` is first seen high after a low sample.
- Completing edge at cycle k → `done` at k+1. Next grant at earliest k+3 (DONE, IDLE, ARM).
- Timeout: COUNT entered at c → `done` at c+TIMEOUT with `result_cycles=TIMEOUT`.
- Target 0: `done` at t+2 with `result_count=0`, `result_cycles=0`, `timed_out=0`.

## Test plan
- **Reset:** `rst` mid-COUNT → next cycle IDLE; `grant=0`, `busy=0`, all results 0, no `done`.
- **Single job:** `req[1]`, `target=3`, three clean pulses on `sig[1]` → `done`, `done_ch=1`, `result_count=3`, `timed_out=0`; `result_cycles` matches the third-edge cycle.
- **Timeout:** `TIMEOUT=20`, `target=5`, two pulses only → `done` 20 cycles after COUNT entry, `timed_out=1`, `result_count=2`, `result_cycles=20`.
- **Round-robin:** `req=4'b1111` held through 5 jobs → grant order 0,1,2,3,0. With `sig[0]` high during the grant, ARM produces no false edge.
- **Simultaneous completion and timeout:** completing edge exactly at `timer=TIMEOUT-1` → `timed_out=0`, `result_count=target`.
- **Target 0 and crosstalk:** `target=0` → `done` two cycles after the request, counts 0. Pulses on non-granted channels during any job → `result_count` unaffected.
